// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding and default timing constants,
// used by the receive deframer and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE        = 16;
  localparam int START_MID         = 7;
  localparam int TICK_BITS         = $clog2(OVERSAMPLE);
  localparam int DEFAULT_BAUD_DIV  = 651;
  localparam int DEFAULT_DIV_BITS  = 10;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_SB_TICK   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider: o_tick is high for one clock at the terminal
// count of a 0..BAUD_DIV-1 counter (one oversample tick).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int DIV_BITS = DEFAULT_DIV_BITS
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic                terminal;

  always_comb begin
    terminal = (cnt_q == DIV_BITS'(BAUD_DIV - 1));
    cnt_d    = terminal ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = terminal;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with 16x oversampling, done/framing-error strobes.
// Define UART_RX_PARITY_EN to add one even-parity bit and o_parity_err.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int SB_TICK   = DEFAULT_SB_TICK,
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int DIV_BITS  = DEFAULT_DIV_BITS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int N_BITS = $clog2(DATA_BITS + 1);
  localparam logic [TICK_BITS-1:0] S_MID  = TICK_BITS'(START_MID);
  localparam logic [TICK_BITS-1:0] S_LAST = TICK_BITS'(OVERSAMPLE - 1);
  localparam logic [TICK_BITS-1:0] S_STOP = TICK_BITS'(SB_TICK - 1);
  localparam logic [N_BITS-1:0]    N_LAST = N_BITS'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [TICK_BITS-1:0] s_q, s_d;
  logic [N_BITS-1:0]    n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 done_q, done_d, ferr_q, ferr_d;
  logic                 tick;
  logic                 parity_bad;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .DIV_BITS (DIV_BITS)
  ) u_baud_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  always_comb begin
    rx_meta_d = i_rx;
    rx_s_d    = rx_meta_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s_q) state_d = ST_START;
      ST_START: if (tick && s_q == S_MID) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick && s_q == S_LAST && n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick && s_q == S_LAST) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick && s_q == S_STOP) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic perr_pend_q, perr_pend_d, perr_q, perr_d;

  // Mismatch is remembered until the stop sample so it can gate o_rx_done.
  always_comb begin
    perr_pend_d = perr_pend_q;
    perr_d      = 1'b0;
    if (state_q == ST_IDLE) perr_pend_d = 1'b0;
    if (state_q == ST_PARITY && tick && s_q == S_LAST)
      perr_pend_d = rx_s_q ^ (^shreg_q);
    if (state_q == ST_STOP && tick && s_q == S_STOP)
      perr_d = perr_pend_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
    end
  end

  assign parity_bad   = perr_pend_q;
  assign o_parity_err = perr_q;
`else
  assign parity_bad   = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  always_comb begin
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: s_d = '0;
      ST_START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            n_d = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = n_q + 1'b1;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
      end
      ST_STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            s_d    = '0;
            ferr_d = ~rx_s_q;
            if (rx_s_q && !parity_bad) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: s_d = '0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_data      = data_q;
    o_rx_done   = done_q;
    o_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: expected strobes are queued as frames
// are driven and matched by a monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int BAUD_DIV = 2;
  localparam int BIT_CLKS = 16 * BAUD_DIV;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       done, ferr, perr, busy;

  typedef struct {
    logic       done;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } event_t;

  event_t     exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clock = ~clock;

  uart_rx_deframer #(
    .DATA_BITS (8),
    .SB_TICK   (16),
    .BAUD_DIV  (BAUD_DIV),
    .DIV_BITS  (4)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset_n),
    .i_rx         (rx),
    .o_data       (data),
    .o_rx_done    (done),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_busy       (busy)
  );

  // Scoreboard: every strobe cycle must match the oldest queued expectation.
  always @(negedge clock) begin
    event_t e;
    if (done || ferr || perr) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_strobe: got done=%b ferr=%b perr=%b data=%h, expected no strobe",
                 done, ferr, perr, data);
      end else begin
        e = exp_q.pop_front();
        if ({done, ferr, perr, data} !== {e.done, e.ferr, e.perr, e.data}) begin
          miscompares++;
          $display("[TB] FAIL strobe: got done=%b ferr=%b perr=%b data=%h, expected done=%b ferr=%b perr=%b data=%h",
                   done, ferr, perr, data, e.done, e.ferr, e.perr, e.data);
        end
      end
    end
  end

  // Bits are LSB-first from bits[0] (start); the last bit is held for 24
  // clocks then released high so a low stop bit cannot look like a new frame.
  task automatic drive_frame(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits - 1; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rx = bits[nbits-1];
    repeat (24) @(negedge clock);
    rx = 1'b1;
    repeat (BIT_CLKS - 24) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val);
`ifdef UART_RX_PARITY_EN
    drive_frame({stop_val, ^d, d, 1'b0}, 11);
`else
    drive_frame({1'b0, stop_val, d, 1'b0}, 10);
`endif
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_missing_strobe: %0d strobes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if ({done, ferr, perr, busy, data} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got done=%b ferr=%b perr=%b busy=%b data=%h, expected all 0",
               done, ferr, perr, busy, data);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      vectors++;
      if ({done, ferr, perr, busy, data} !== 12'h000) begin
        miscompares++;
        $display("[TB] FAIL idle_outputs cycle %0d: got done=%b ferr=%b perr=%b busy=%b data=%h, expected all 0",
                 i, done, ferr, perr, busy, data);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1);
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1);
    repeat (8) @(negedge clock);
    check_drained("back_to_back");
    last_good = 8'h3C;
    vectors++;
    if (data !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL b2b_data_hold: got %h, expected 3c", data);
    end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_rise: got %b, expected 1", busy);
    end
    repeat (40) @(negedge clock);
    vectors++;
    if ({busy, data} !== {1'b0, last_good}) begin
      miscompares++;
      $display("[TB] FAIL glitch_abort: got busy=%b data=%h, expected busy=0 data=%h", busy, data, last_good);
    end
    check_drained("glitch");
  endtask

  task automatic test_frame_error;
    exp_q.push_back('{1'b0, 1'b1, 1'b0, last_good});
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clock);
    check_drained("frame_error");
    vectors++;
    if ({busy, data} !== {1'b0, 8'h3C}) begin
      miscompares++;
      $display("[TB] FAIL ferr_data_hold: got busy=%b data=%h, expected busy=0 data=3c", busy, data);
    end
  endtask

  task automatic test_reset_mid_frame;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock);
    rx = 1'b1;
    repeat (100) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midframe_busy: got %b, expected 1", busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, data} !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset: got busy=%b data=%h, expected busy=0 data=00", busy, data);
    end
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    check_drained("reset_mid_frame");
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    repeat (8) @(negedge clock);
    check_drained("after_reset");
    last_good = 8'h81;
    vectors++;
    if (data !== 8'h81) begin
      miscompares++;
      $display("[TB] FAIL after_reset_data: got %h, expected 81", data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'h07});
    drive_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (8) @(negedge clock);
    check_drained("parity_good");
    last_good = 8'h07;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 8'h07});
    drive_frame({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (8) @(negedge clock);
    check_drained("parity_bad");
    vectors++;
    if (data !== 8'h07) begin
      miscompares++;
      $display("[TB] FAIL parity_data_hold: got %h, expected 07", data);
    end
  endtask
`endif

  initial begin
    $display("[TB] uart_rx_deframer bench start");
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
